// File: rtl/prf_pkg.sv
// Shared sizing, types and helpers for the physical register file.
package prf_pkg;
  localparam int DATA_W    = 16;
  localparam int NUM_PREGS = 16;
  localparam int NUM_AREGS = 8;
  localparam int NUM_RD    = 4;
  localparam int NUM_WB    = 2;
  localparam int NUM_ALLOC = 2;
  localparam int TAG_W     = $clog2(NUM_PREGS);

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [DATA_W-1:0] data_t;

  function automatic int unsigned popcount(input logic [63:0] v);
    popcount = 0;
    for (int i = 0; i < 64; i++) popcount += 32'(v[i]);
  endfunction
endpackage

// File: rtl/prf_free_pick.sv
// Picks the lowest SLOTS set bits of a free vector, ascending by slot index.
module prf_free_pick #(
  parameter  int N     = 16,
  parameter  int SLOTS = 2,
  localparam int TW    = $clog2(N)
) (
  input  logic [N-1:0]              i_free,
  output logic [SLOTS-1:0]          o_vld,
  output logic [SLOTS-1:0][TW-1:0]  o_tag
);
  always_comb begin : pick
    logic [N-1:0] w_rem;
    logic         w_hit;
    w_rem = i_free;
    o_vld = '0;
    o_tag = '0;
    for (int s = 0; s < SLOTS; s++) begin
      w_hit = 1'b0;
      for (int t = 0; t < N; t++) begin
        if (w_rem[t] && !w_hit) begin
          w_hit    = 1'b1;
          o_vld[s] = 1'b1;
          o_tag[s] = TW'(t);
          w_rem[t] = 1'b0;
        end
      end
    end
  end
endmodule

// File: rtl/prf_multiport.sv
// Physical register file with free list, ready table, writeback bypass,
// commit release and single-cycle flush rebuild from the architectural map.
module prf_multiport import prf_pkg::*; #(
  parameter  int DATA_W    = prf_pkg::DATA_W,
  parameter  int NUM_PREGS = prf_pkg::NUM_PREGS,
  parameter  int NUM_AREGS = prf_pkg::NUM_AREGS,
  parameter  int NUM_RD    = prf_pkg::NUM_RD,
  parameter  int NUM_WB    = prf_pkg::NUM_WB,
  parameter  int NUM_ALLOC = prf_pkg::NUM_ALLOC,
  localparam int TAG_W     = $clog2(NUM_PREGS),
  localparam int CW        = TAG_W + 1
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [NUM_ALLOC-1:0]                i_alloc_req,
  output logic [NUM_ALLOC-1:0]                o_alloc_gnt,
  output logic [NUM_ALLOC-1:0][TAG_W-1:0]     o_alloc_tag,
  output logic [CW-1:0]                       o_free_cnt,
  input  logic [NUM_RD-1:0][TAG_W-1:0]        i_rd_tag,
  output logic [NUM_RD-1:0][DATA_W-1:0]       o_rd_data,
  output logic [NUM_RD-1:0]                   o_rd_ready,
  input  logic [NUM_WB-1:0]                   i_wb_valid,
  input  logic [NUM_WB-1:0][TAG_W-1:0]        i_wb_tag,
  input  logic [NUM_WB-1:0][DATA_W-1:0]       i_wb_data,
  input  logic                                i_cmt_valid,
  input  logic [TAG_W-1:0]                    i_cmt_tag_old,
  input  logic                                i_flush,
  input  logic [NUM_AREGS-1:0][TAG_W-1:0]     i_arf_tag
);
  logic [NUM_PREGS-1:0][DATA_W-1:0] r_data;
  logic [NUM_PREGS-1:0]             r_ready, r_free;
  logic [CW-1:0]                    r_free_cnt;

  logic [NUM_ALLOC-1:0]             w_slot_vld;
  logic [NUM_ALLOC-1:0][TAG_W-1:0]  w_slot_tag;
  logic [CW-1:0]                    w_nreq;
  logic                             w_grant_all;
  logic [NUM_PREGS-1:0]             w_free_nxt, w_ready_nxt;
  logic                             w_wb_dup, w_dbl_free;

  assign o_free_cnt = r_free_cnt;

  prf_free_pick #(.N(NUM_PREGS), .SLOTS(NUM_ALLOC)) u_pick (
    .i_free (r_free),
    .o_vld  (w_slot_vld),
    .o_tag  (w_slot_tag)
  );

  // All-or-nothing grant; requesting lanes consume pick slots in lane order.
  always_comb begin : alloc
    logic [CW-1:0] w_slot;
    w_nreq      = CW'(popcount(64'(i_alloc_req)));
    w_grant_all = !i_flush && (w_nreq <= r_free_cnt);
    w_slot      = '0;
    o_alloc_gnt = '0;
    o_alloc_tag = '0;
    for (int l = 0; l < NUM_ALLOC; l++) begin
      if (i_alloc_req[l] && w_grant_all) begin
        for (int s = 0; s < NUM_ALLOC; s++) begin
          if (CW'(s) == w_slot && w_slot_vld[s]) begin
            o_alloc_gnt[l] = 1'b1;
            o_alloc_tag[l] = w_slot_tag[s];
          end
        end
        w_slot = w_slot + CW'(1);
      end
    end
  end

  // Writeback sets ready, allocation then clears it so a stale wb loses.
  always_comb begin
    w_free_nxt  = r_free;
    w_ready_nxt = r_ready;
    for (int w = 0; w < NUM_WB; w++)
      if (i_wb_valid[w] && i_wb_tag[w] != '0) w_ready_nxt[i_wb_tag[w]] = 1'b1;
    for (int l = 0; l < NUM_ALLOC; l++) begin
      if (o_alloc_gnt[l]) begin
        w_ready_nxt[o_alloc_tag[l]] = 1'b0;
        w_free_nxt[o_alloc_tag[l]]  = 1'b0;
      end
    end
    if (i_cmt_valid && i_cmt_tag_old != '0) w_free_nxt[i_cmt_tag_old] = 1'b1;
    if (i_flush) begin
      w_free_nxt    = '1;
      w_free_nxt[0] = 1'b0;
      for (int a = 0; a < NUM_AREGS; a++) w_free_nxt[i_arf_tag[a]] = 1'b0;
      w_ready_nxt   = '1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int t = 0; t < NUM_PREGS; t++) r_free[t] <= (t >= NUM_AREGS);
      r_ready    <= '1;
      r_free_cnt <= CW'(NUM_PREGS - NUM_AREGS);
    end else begin
      r_free     <= w_free_nxt;
      r_ready    <= w_ready_nxt;
      r_free_cnt <= CW'(popcount(64'(w_free_nxt)));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_data <= '0;
    else if (!i_flush)
      for (int w = 0; w < NUM_WB; w++)
        if (i_wb_valid[w] && i_wb_tag[w] != '0) r_data[i_wb_tag[w]] <= i_wb_data[w];
  end

  // Array read overlaid by in-flight writeback; higher wb lane has priority.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    always_comb begin
      o_rd_data[p]  = r_data[i_rd_tag[p]];
      o_rd_ready[p] = r_ready[i_rd_tag[p]];
      if (!i_flush)
        for (int w = 0; w < NUM_WB; w++)
          if (i_wb_valid[w] && i_wb_tag[w] != '0 && i_wb_tag[w] == i_rd_tag[p]) begin
            o_rd_data[p]  = i_wb_data[w];
            o_rd_ready[p] = 1'b1;
          end
      if (i_rd_tag[p] == '0) begin
        o_rd_data[p]  = '0;
        o_rd_ready[p] = 1'b1;
      end
    end
  end

  always_comb begin
    w_wb_dup = 1'b0;
    for (int a = 0; a < NUM_WB; a++)
      for (int b = a + 1; b < NUM_WB; b++)
        if (i_wb_valid[a] && i_wb_valid[b] && i_wb_tag[a] == i_wb_tag[b] && i_wb_tag[a] != '0)
          w_wb_dup = 1'b1;
    w_dbl_free = i_cmt_valid && i_cmt_tag_old != '0 && r_free[i_cmt_tag_old];
  end

  a_wb_dup:   assert property (@(posedge i_clk) disable iff (i_rst) !(w_wb_dup && !i_flush));
  a_dbl_free: assert property (@(posedge i_clk) disable iff (i_rst) !(w_dbl_free && !i_flush));
endmodule

// File: tb/tb_prf_multiport.sv
// Randomized and directed checking of prf_multiport against a set/array model.
module tb_prf_multiport;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic [1:0]        alloc_req = '0, alloc_gnt;
  logic [1:0][3:0]   alloc_tag;
  logic [4:0]        free_cnt;
  logic [3:0][3:0]   rd_tag = '0;
  logic [3:0][15:0]  rd_data;
  logic [3:0]        rd_ready;
  logic [1:0]        wb_valid = '0;
  logic [1:0][3:0]   wb_tag = '0;
  logic [1:0][15:0]  wb_data = '0;
  logic              cmt_valid = 1'b0;
  logic [3:0]        cmt_tag_old = '0;
  logic              flush = 1'b0;
  logic [7:0][3:0]   arf_tag = '0;

  prf_multiport dut (
    .i_clk(clk), .i_rst(rst),
    .i_alloc_req(alloc_req), .o_alloc_gnt(alloc_gnt), .o_alloc_tag(alloc_tag),
    .o_free_cnt(free_cnt),
    .i_rd_tag(rd_tag), .o_rd_data(rd_data), .o_rd_ready(rd_ready),
    .i_wb_valid(wb_valid), .i_wb_tag(wb_tag), .i_wb_data(wb_data),
    .i_cmt_valid(cmt_valid), .i_cmt_tag_old(cmt_tag_old),
    .i_flush(flush), .i_arf_tag(arf_tag)
  );

  typedef struct {
    logic [1:0]       gnt;
    logic [1:0][3:0]  tag;
    logic [3:0][15:0] rdd;
    logic [3:0]       rdr;
    logic [4:0]       cnt;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0, n_bad = 0;

  // Reference state: data per tag, ready per tag, membership of the free set.
  logic [15:0][15:0] md;
  logic [15:0]       mr, mf;

  logic [1:0]        s_req;
  logic [3:0][3:0]   s_rt;
  logic [1:0]        s_wv;
  logic [1:0][3:0]   s_wt;
  logic [1:0][15:0]  s_wd;
  logic              s_cv;
  logic [3:0]        s_ct;
  logic              s_fl;
  logic [7:0][3:0]   s_arf;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    s_req = '0; s_rt = '0; s_wv = '0; s_wt = '0; s_wd = '0;
    s_cv = 1'b0; s_ct = '0; s_fl = 1'b0; s_arf = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; alloc_req = '0; wb_valid = '0; cmt_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    md = '0; mr = '1; mf = 16'hFF00;
  endtask

  task automatic step();
    exp_t e;
    int   q[$];
    int   k;
    @(negedge clk);
    alloc_req = s_req; rd_tag = s_rt; wb_valid = s_wv; wb_tag = s_wt; wb_data = s_wd;
    cmt_valid = s_cv; cmt_tag_old = s_ct; flush = s_fl; arf_tag = s_arf;
    for (int t = 0; t < 16; t++) if (mf[t]) q.push_back(t);
    e.cnt = 5'(q.size());
    e.gnt = '0; e.tag = '0;
    if (!s_fl && $countones(s_req) <= q.size()) begin
      k = 0;
      for (int l = 0; l < 2; l++)
        if (s_req[l]) begin e.gnt[l] = 1'b1; e.tag[l] = 4'(q[k]); k++; end
    end
    for (int p = 0; p < 4; p++) begin
      e.rdd[p] = md[s_rt[p]];
      e.rdr[p] = mr[s_rt[p]];
      if (!s_fl)
        for (int w = 0; w < 2; w++)
          if (s_wv[w] && s_wt[w] != 0 && s_wt[w] == s_rt[p]) begin
            e.rdd[p] = s_wd[w]; e.rdr[p] = 1'b1;
          end
    end
    sbq.push_back(e);
    if (s_fl) begin
      mf = 16'hFFFE;
      for (int a = 0; a < 8; a++) mf[s_arf[a]] = 1'b0;
      mr = '1;
    end else begin
      for (int w = 0; w < 2; w++)
        if (s_wv[w] && s_wt[w] != 0) begin md[s_wt[w]] = s_wd[w]; mr[s_wt[w]] = 1'b1; end
      for (int l = 0; l < 2; l++)
        if (e.gnt[l]) begin mr[e.tag[l]] = 1'b0; mf[e.tag[l]] = 1'b0; end
      if (s_cv && s_ct != 0) mf[s_ct] = 1'b1;
    end
  endtask

  // Monitor: outputs are combinational, so compare mid-cycle after each drive.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("free_cnt", 64'(free_cnt), 64'(e.cnt));
        chk("alloc_gnt", 64'(alloc_gnt), 64'(e.gnt));
        chk("alloc_tag", 64'(alloc_tag), 64'(e.tag));
        for (int p = 0; p < 4; p++) begin
          chk($sformatf("rd_data[%0d]", p), 64'(rd_data[p]), 64'(e.rdd[p]));
          chk($sformatf("rd_ready[%0d]", p), 64'(rd_ready[p]), 64'(e.rdr[p]));
        end
      end
    end
  end

  initial begin
    logic [15:0] busy;
    int          nb;
    int          pick;
    clr();
    do_reset();
    // Reset contents of the architectural tags, then first grant 8,9.
    s_rt = {4'd3, 4'd2, 4'd1, 4'd0}; step();
    s_rt = {4'd7, 4'd6, 4'd5, 4'd4}; step();
    clr(); s_req = 2'b11; repeat (4) step();
    s_req = 2'b01; step();
    s_cv = 1'b1; s_ct = 4'd3; step();
    clr(); s_req = 2'b01; step();
    clr(); s_cv = 1'b1; s_ct = 4'd3; step();
    clr(); s_req = 2'b11; step();
    s_req = 2'b10; step();
    clr(); s_req = 2'b01; step();
    // Same-cycle bypass, then array read.
    do_reset();
    clr(); s_req = 2'b01; s_rt[1] = 4'd8; step();
    clr(); s_wv = 2'b10; s_wt[1] = 4'd8; s_wd[1] = 16'hBEEF; s_rt[0] = 4'd8; step();
    clr(); s_rt[0] = 4'd8; step();
    // Alloc and wb of the same tag: alloc wins the ready bit.
    clr(); s_req = 2'b01; s_wv = 2'b01; s_wt[0] = 4'd9; s_wd[0] = 16'h1234; step();
    clr(); s_rt[2] = 4'd9; step();
    // Flush recovery.
    do_reset();
    clr(); s_req = 2'b11; step(); step();
    clr(); s_fl = 1'b1; s_req = 2'b11; s_wv = 2'b01; s_wt[0] = 4'd9; s_wd[0] = 16'hDEAD;
    s_rt[0] = 4'd9;
    s_arf = {4'd7, 4'd6, 4'd5, 4'd4, 4'd8, 4'd2, 4'd1, 4'd0}; step();
    clr(); s_req = 2'b01; s_rt[0] = 4'd9; step();
    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(149) == 0) do_reset();
      clr();
      s_req = 2'($urandom);
      for (int p = 0; p < 4; p++) s_rt[p] = 4'($urandom);
      s_wv = 2'($urandom);
      s_wt[0] = 4'($urandom); s_wt[1] = 4'($urandom);
      s_wd[0] = 16'($urandom); s_wd[1] = 16'($urandom);
      if (s_wv == 2'b11 && s_wt[0] == s_wt[1] && s_wt[0] != 0) s_wv[0] = 1'b0;
      busy = ~mf; busy[0] = 1'b0;
      nb = $countones(busy);
      if (nb > 0 && $urandom_range(2) != 0) begin
        pick = $urandom_range(nb - 1);
        for (int t = 1; t < 16; t++)
          if (busy[t]) begin
            if (pick == 0) begin s_cv = 1'b1; s_ct = 4'(t); end
            pick--;
          end
      end
      if ($urandom_range(24) == 0) begin
        s_fl = 1'b1;
        for (int a = 0; a < 8; a++) s_arf[a] = 4'($urandom);
      end
      step();
    end
    @(negedge clk);
    alloc_req = '0; wb_valid = '0; cmt_valid = 1'b0; flush = 1'b0;
    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge clk);
    #3;
    if (sbq.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
